color_table_aga: RTL and testbench
==================================

Name: color_table_aga

Overview:
- Parametrised successor of the OCS/ECS 32x12 colour look-up table for the Denise re-implementation.
- Default geometry is 256 entries x 24 bits, AGA style.
- Supports bank-selected CPU/Copper writes, split high/low nibble writes (LOCT), write-first forwarding and a configurable read pipeline depth.
- Runs a post-reset clear walk to black.
- Sits between the playfield/sprite priority logic (read side) and the register decoder (write side).

Parameters:
IDX_W, 8, table index width; DEPTH = 2**IDX_W, must be >= 5 (minimum 32 entries)
CH_W, 8, bits per colour channel; must be even; HALF = CH_W/2
READ_LAT, 2, read latency in clocks, 1..4
INIT_EN, 1, 1 = clear walk after reset; 0 = no walk, table contents undefined until written

Ports:
clk  in  1  28 MHz pixel clock
rst  in  1  synchronous active-high reset
cpu_wr  in  1  colour register write strobe
cpu_idx  in  5  COLORxx register number 0..31
cpu_bank  in  IDX_W-5  bank select (BPLCON3 BANK); entry address = {cpu_bank, cpu_idx}
cpu_loct  in  1  0 = high-nibble write, 1 = low-nibble write
cpu_rgb  in  3*HALF  {R,G,B} nibbles, HALF bits each
clut_rd  in  1  read request
clut_idx  in  IDX_W  read address
clut_rgb  out  3*CH_W  {R,G,B} full-width colour
clut_vld  out  1  clut_rgb carries the result of a request issued READ_LAT clocks earlier
init_busy  out  1  clear walk in progress

Behaviour:
- Storage is two arrays of DEPTH x 3*HALF: hi_mem and lo_mem.
- Stored colour = per channel {hi, lo}. No read-modify-write is needed.
- High write (cpu_wr=1, cpu_loct=0): writes cpu_rgb to hi_mem[a] and to lo_mem[a]. This is the OCS-compatible nibble duplication.
- Low write (cpu_wr=1, cpu_loct=1): writes lo_mem[a] only; hi_mem[a] is unchanged.
- Read, stage 0: when clut_rd=1, the array data at clut_idx is captured into a stage register.
  - Forwarding on the same cycle: if cpu_wr targets clut_idx, the captured value already reflects that write (write-first).
  - For a low write, the captured high part comes from the array and the low part comes from cpu_rgb.
  - When clut_rd=0, the stage register holds its value.
- Read, stages 1..READ_LAT-1: plain delay registers that always advance.
  - clut_rgb is the last stage register; with READ_LAT=1 it is the stage-0 register.
- clut_vld: clut_rd delayed by READ_LAT clocks through its own shift register, which always advances.
- A write issued the cycle after a read sample does not alter that read's result.
- Reset state machine, two states:
  - On rst=1: enter INIT if INIT_EN=1, else enter RUN. The walk counter is cleared to 0.
  - The data pipeline, clut_rgb, and the clut_vld shift register are all cleared to 0.
  - INIT: each clock writes 0 to hi_mem[cnt] and lo_mem[cnt] and increments cnt. After entry DEPTH-1 is written, go to RUN.
    - The walk takes exactly DEPTH clocks after rst deasserts.
    - init_busy = 1 throughout INIT.
  - RUN: normal operation; init_busy = 0.
- During INIT:
  - CPU writes are dropped; there is no queue.
  - Reads still pipeline, and clut_vld still follows clut_rd. The returned data is 0, forced at stage 0.
- rst asserted during INIT restarts the walk at entry 0.
- rst asserted during RUN does not clear the arrays unless INIT_EN=1, which triggers a full re-walk.
- Reset values: clut_rgb = 0; clut_vld = 0; init_busy = 1 if INIT_EN, else 0.
- Indices and the bank are never out of range; address arithmetic wraps naturally at DEPTH.

Decomposition:
- Package denise_clut_pkg holds:
  - localparams CLUT_IDX_W = 8, CLUT_CH_W = 8;
  - the state enum {CLUT_INIT, CLUT_RUN};
  - a function expand_rgb(hi, lo) that interleaves the nibbles into {R,G,B}.
- One sub-module, clut_dpram: a simple dual-port RAM, one write port and one asynchronous-read port, width 3*HALF, instantiated twice (hi and lo).
- The FSM, forwarding and pipeline stay in color_table_aga.

Test Plan:
- Reset, then hold clut_rd=1, clut_idx=0xFF from the first cycle:
  - init_busy stays 1 for exactly 256 clocks;
  - clut_vld rises at clock 2 with clut_rgb = 0x000000.
- After init: bank=3, idx=5, loct=0, rgb=0xF84. Then read idx 0x65 with READ_LAT=2 → two clocks later clut_rgb = 0xFF8844, clut_vld = 1.
- Then loct=1, rgb=0x1A3 to the same entry, then read → clut_rgb = 0xF18A43. Other entries still read 0.
- Same-cycle high write idx 0x10, rgb=0x123, with clut_rd at 0x10 → the result is 0x112233 (forwarded). A write on the following cycle does not change it.
- During INIT, write rgb=0xFFF to idx 0 → after init, read idx 0 returns 0x000000.
- rst pulsed at walk step 100 → init_busy remains 1 for a further 256 clocks. Repeat all scenarios with READ_LAT=1 and READ_LAT=4, checking the latency shifts accordingly.

Source files
------------

// File: rtl/denise_clut_pkg.sv
// Shared types and helpers for the Denise AGA colour look-up table.
package denise_clut_pkg;

  localparam int unsigned CLUT_IDX_W    = 8;
  localparam int unsigned CLUT_CH_W     = 8;
  localparam int unsigned CLUT_MAX_CH_W = 16;
  localparam int unsigned CLUT_MAX_HALF = CLUT_MAX_CH_W / 2;

  typedef enum logic {
    CLUT_INIT,
    CLUT_RUN
  } clut_state_e;

  // Interleave packed {R,G,B} high and low nibble groups into full channels {hi,lo}.
  function automatic logic [3*CLUT_MAX_CH_W-1:0] expand_rgb(
    input logic [3*CLUT_MAX_HALF-1:0] hi,
    input logic [3*CLUT_MAX_HALF-1:0] lo,
    input int unsigned                half
  );
    logic [3*CLUT_MAX_CH_W-1:0] rgb;
    rgb = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      for (int unsigned b = 0; b < CLUT_MAX_HALF; b++) begin
        if (b < half) begin
          rgb[c*2*half + half + b] = hi[c*half + b];
          rgb[c*2*half + b]        = lo[c*half + b];
        end
      end
    end
    return rgb;
  endfunction

endpackage

// File: rtl/clut_dpram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
module clut_dpram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/color_table_aga.sv
// AGA colour look-up table: banked nibble writes, write-first read forwarding,
// configurable read latency and a post-reset clear walk.
module color_table_aga
  import denise_clut_pkg::*;
#(
  parameter int unsigned IDX_W    = CLUT_IDX_W,
  parameter int unsigned CH_W     = CLUT_CH_W,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned INIT_EN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_wr,
  input  logic [4:0]              cpu_idx,
  input  logic [IDX_W-6:0]        cpu_bank,
  input  logic                    cpu_loct,
  input  logic [3*(CH_W/2)-1:0]   cpu_rgb,
  input  logic                    clut_rd,
  input  logic [IDX_W-1:0]        clut_idx,
  output logic [3*CH_W-1:0]       clut_rgb,
  output logic                    clut_vld,
  output logic                    init_busy
);

  localparam int unsigned HALF = CH_W / 2;
  localparam int unsigned PW   = 3 * HALF;
  localparam int unsigned RW   = 3 * CH_W;

  clut_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [RW-1:0]       pipe_q [READ_LAT];
  logic [RW-1:0]       pipe_d [READ_LAT];
  logic [READ_LAT-1:0] vld_q, vld_d;

  logic             in_init;
  logic [IDX_W-1:0] cpu_addr;
  logic             cpu_we;
  logic             hi_we, lo_we;
  logic [IDX_W-1:0] waddr;
  logic [PW-1:0]    wdata;
  logic [PW-1:0]    hi_rdata, lo_rdata;
  logic [PW-1:0]    fwd_hi, fwd_lo;
  logic [3*CLUT_MAX_HALF-1:0] hi_ext, lo_ext;
  logic [RW-1:0]    s0_val;

  clut_dpram #(.AW(IDX_W), .DW(PW)) u_hi_mem (
    .clk   (clk),
    .we    (hi_we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (clut_idx),
    .rdata (hi_rdata)
  );

  clut_dpram #(.AW(IDX_W), .DW(PW)) u_lo_mem (
    .clk   (clk),
    .we    (lo_we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (clut_idx),
    .rdata (lo_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_init = (state_q == CLUT_INIT);

    if (in_init) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = CLUT_RUN;
      end
    end

    cpu_addr = {cpu_bank, cpu_idx};
    cpu_we   = cpu_wr && !rst && !in_init;

    // The clear walk owns the write port; CPU writes in that window are dropped.
    if (in_init) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      waddr = cnt_q;
      wdata = '0;
    end else begin
      hi_we = cpu_we && !cpu_loct;
      lo_we = cpu_we;
      waddr = cpu_addr;
      wdata = cpu_rgb;
    end

    fwd_hi = hi_rdata;
    fwd_lo = lo_rdata;
    if (cpu_we && (cpu_addr == clut_idx)) begin
      fwd_lo = cpu_rgb;
      if (!cpu_loct) begin
        fwd_hi = cpu_rgb;
      end
    end

    hi_ext         = '0;
    lo_ext         = '0;
    hi_ext[PW-1:0] = fwd_hi;
    lo_ext[PW-1:0] = fwd_lo;
    s0_val = in_init ? '0 : RW'(expand_rgb(hi_ext, lo_ext, HALF));

    pipe_d[0] = clut_rd ? s0_val : pipe_q[0];
    vld_d[0]  = clut_rd;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
      vld_d[i]  = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_EN != 0) ? CLUT_INIT : CLUT_RUN;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign clut_rgb  = pipe_q[READ_LAT-1];
  assign clut_vld  = vld_q[READ_LAT-1];
  assign init_busy = (state_q == CLUT_INIT);

endmodule

// File: tb/tb_color_table_aga.sv
// Bench for color_table_aga at read latencies 1, 2 and 4 against a colour-table model.
module tb_color_table_aga;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_wr;
  logic [4:0]  cpu_idx;
  logic [2:0]  cpu_bank;
  logic        cpu_loct;
  logic [11:0] cpu_rgb;
  logic        clut_rd;
  logic [7:0]  clut_idx;

  logic [23:0] rgb1, rgb2, rgb4;
  logic        vld1, vld2, vld4;
  logic        busy1, busy2, busy4;

  color_table_aga #(.IDX_W(8), .CH_W(8), .READ_LAT(1), .INIT_EN(1)) u_lat1 (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_idx(cpu_idx), .cpu_bank(cpu_bank),
    .cpu_loct(cpu_loct), .cpu_rgb(cpu_rgb), .clut_rd(clut_rd), .clut_idx(clut_idx),
    .clut_rgb(rgb1), .clut_vld(vld1), .init_busy(busy1));

  color_table_aga #(.IDX_W(8), .CH_W(8), .READ_LAT(2), .INIT_EN(1)) u_lat2 (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_idx(cpu_idx), .cpu_bank(cpu_bank),
    .cpu_loct(cpu_loct), .cpu_rgb(cpu_rgb), .clut_rd(clut_rd), .clut_idx(clut_idx),
    .clut_rgb(rgb2), .clut_vld(vld2), .init_busy(busy2));

  color_table_aga #(.IDX_W(8), .CH_W(8), .READ_LAT(4), .INIT_EN(1)) u_lat4 (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_idx(cpu_idx), .cpu_bank(cpu_bank),
    .cpu_loct(cpu_loct), .cpu_rgb(cpu_rgb), .clut_rd(clut_rd), .clut_idx(clut_idx),
    .clut_rgb(rgb4), .clut_vld(vld4), .init_busy(busy4));

  // Reference: nibble arrays, clocks left in the clear walk, issued-request history.
  logic [11:0] m_hi [256];
  logic [11:0] m_lo [256];
  int          walk_left = 0;
  logic        hv [5];
  logic [23:0] hr [5];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [23:0] color_of(input logic [11:0] h, input logic [11:0] l);
    int unsigned hu, lu, acc;
    hu  = h;
    lu  = l;
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      acc += ((((hu >> (4*c)) & 15) * 16) + ((lu >> (4*c)) & 15)) << (8*c);
    end
    return acc[23:0];
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_dut(input string tag, input int lat, input logic [23:0] rgb,
                         input logic vld, input logic busy);
    chk({tag, "_busy"}, {23'd0, busy}, {23'd0, (walk_left > 0)});
    chk({tag, "_vld"}, {23'd0, vld}, {23'd0, hv[lat-1]});
    if (hv[lat-1]) chk({tag, "_rgb"}, rgb, hr[lat-1]);
  endtask

  task automatic tick();
    logic        rv;
    logic [23:0] rval;
    int          wnext;
    logic [7:0]  a;
    rv    = 1'b0;
    rval  = '0;
    wnext = walk_left;
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        m_hi[i] = '0;
        m_lo[i] = '0;
      end
      wnext = 256;
    end else if (walk_left > 0) begin
      rv    = clut_rd;
      wnext = walk_left - 1;
    end else begin
      if (cpu_wr) begin
        a       = {cpu_bank, cpu_idx};
        m_lo[a] = cpu_rgb;
        if (!cpu_loct) m_hi[a] = cpu_rgb;
      end
      rv   = clut_rd;
      rval = color_of(m_hi[clut_idx], m_lo[clut_idx]);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        hv[i] = 1'b0;
        hr[i] = '0;
      end
    end else begin
      for (int i = 4; i > 0; i--) begin
        hv[i] = hv[i-1];
        hr[i] = hr[i-1];
      end
      hv[0] = rv;
      hr[0] = rval;
    end
    walk_left = wnext;
    chk_dut("lat1", 1, rgb1, vld1, busy1);
    chk_dut("lat2", 2, rgb2, vld2, busy2);
    chk_dut("lat4", 4, rgb4, vld4, busy4);
  endtask

  task automatic settle(input int n);
    clut_rd = 1'b0;
    cpu_wr  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chk_all(input string tag, input logic [23:0] expv);
    chk({tag, "_l1"}, rgb1, expv);
    chk({tag, "_l2"}, rgb2, expv);
    chk({tag, "_l4"}, rgb4, expv);
  endtask

  task automatic cpu_write(input logic [2:0] bank, input logic [4:0] idx,
                           input logic loct, input logic [11:0] rgb);
    cpu_wr   = 1'b1;
    cpu_bank = bank;
    cpu_idx  = idx;
    cpu_loct = loct;
    cpu_rgb  = rgb;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic read_once(input logic [7:0] idx);
    clut_rd  = 1'b1;
    clut_idx = idx;
    tick();
    clut_rd = 1'b0;
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_wr   = ($urandom_range(0, 2) == 0);
      cpu_bank = 3'($urandom_range(0, 7));
      cpu_idx  = 5'($urandom_range(0, 31));
      cpu_loct = 1'($urandom_range(0, 1));
      cpu_rgb  = 12'($urandom_range(0, 4095));
      clut_rd  = 1'($urandom_range(0, 1));
      clut_idx = ($urandom_range(0, 1) == 0) ? {cpu_bank, cpu_idx} : 8'($urandom_range(0, 255));
      tick();
    end
    settle(1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 5; i++) begin
      hv[i] = 1'b0;
      hr[i] = '0;
    end
    rst = 1'b1; cpu_wr = 1'b0; cpu_idx = '0; cpu_bank = '0; cpu_loct = 1'b0;
    cpu_rgb = '0; clut_rd = 1'b0; clut_idx = '0;
    tick();
    tick();
    chk_all("reset_rgb", 24'h000000);
    chk("reset_vld", {21'd0, vld1, vld2, vld4}, 24'd0);
    chk("reset_busy", {21'd0, busy1, busy2, busy4}, 24'h7);

    // Walk with a read held on 0xFF and a dropped write to entry 0.
    rst = 1'b0;
    clut_rd = 1'b1;
    clut_idx = 8'hFF;
    n = 0;
    while (busy2 === 1'b1 && n < 600) begin
      if (n == 10) begin
        cpu_wr = 1'b1; cpu_bank = 3'd0; cpu_idx = 5'd0; cpu_loct = 1'b0; cpu_rgb = 12'hFFF;
      end else begin
        cpu_wr = 1'b0;
      end
      tick();
      n++;
      if (n == 1) chk("vld2_clk1", {23'd0, vld2}, 24'd0);
      if (n == 2) begin
        chk("vld2_clk2", {23'd0, vld2}, 24'd1);
        chk("rgb2_clk2", rgb2, 24'h000000);
      end
    end
    chk("init_len", 24'(n), 24'd256);
    settle(2);

    cpu_write(3'd3, 5'd5, 1'b0, 12'hF84);
    read_once(8'h65);
    settle(5);
    chk_all("hi_write", 24'hFF8844);

    cpu_write(3'd3, 5'd5, 1'b1, 12'h1A3);
    read_once(8'h65);
    settle(5);
    chk_all("lo_write", 24'hF18A43);

    read_once(8'h64);
    settle(5);
    chk_all("other_entry", 24'h000000);

    read_once(8'h00);
    settle(5);
    chk_all("init_dropped_wr", 24'h000000);

    // Same-cycle write and read forward; next-cycle write must not disturb it.
    cpu_wr = 1'b1; cpu_bank = 3'd0; cpu_idx = 5'h10; cpu_loct = 1'b0; cpu_rgb = 12'h123;
    clut_rd = 1'b1; clut_idx = 8'h10;
    tick();
    clut_rd = 1'b0; cpu_rgb = 12'hABC;
    tick();
    settle(5);
    chk_all("forward", 24'h112233);
    read_once(8'h10);
    settle(5);
    chk_all("after_fwd", 24'hAABBCC);

    random_ops(400);

    // Reset mid-walk at step 100 restarts the full walk.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      clut_rd  = 1'($urandom_range(0, 1));
      clut_idx = 8'($urandom_range(0, 255));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clut_rd = 1'b0;
    n = 0;
    while (busy4 === 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("rewalk_len", 24'(n), 24'd256);
    read_once(8'h65);
    settle(5);
    chk_all("rewalk_cleared", 24'h000000);

    random_ops(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
